mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle control state machine for the single-ALU CPU datapath. Sequences each instruction through IF/ID/EX/MEM/WB, drives every datapath enable and mux select, and configures the immediate extender by driving its 2-bit `EXTOp` select (00 unsigned, 01 signed, 10 instruction/zero). Sits between the instruction register and the datapath. Stalls on a memory ready handshake.

## Interface
Parameters:
- `STATE_W`, 3: state register width. Fixed for the five-state encoding.

Ports:
- `clk`  in  1  system clock. State updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  IR[31:26]. Valid from the first cycle of ID.
- `funct`  in  6  IR[5:0]. Valid from the first cycle of ID.
- `mem_ready`  in  1  memory completion for the current IF or MEM access.
- `PCWrite`, `PCWriteCond`, `IRWrite`, `RegWrite`, `MemRead`, `MemWrite`  out  1 each  datapath enables.
- `RegDst`, `MemToReg`, `ALUSrcA`  out  1 each  mux selects.
- `ALUSrcB`  out  2  ALU B select: 00 reg, 01 const 4, 10 ext imm, 11 ext imm<<2.
- `ALUOp`  out  3  ALU function: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT.
- `PCSource`  out  2  PC select: 00 ALU, 01 ALUOut, 10 jump target.
- `EXTOp`  out  2  extender select.
- `state`  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4.
- `illegal`  out  1  sticky flag for an undecoded instruction.

## Operation
- Registered elements:
  - `state`.
  - `op_q` / `funct_q`, captured on the ID→next edge.
  - `illegal`.
- All other outputs are combinational from `state`. Within ID they also use live `opcode`/`funct`; after ID they use `op_q`/`funct_q`. Unlisted outputs are 0.
- Reset (async):
  - `state`=IF, `op_q`=`funct_q`=0, `illegal`=0.
  - While `rst`=1, every write enable (PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite) is forced to 0.
- Decoded set:
  - R-type (opcode 000000): funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - addi 001000, addiu 001001: EXTOp=01.
  - andi 001100, ori 001101: EXTOp=00.
  - lw 100011, sw 101011, beq 000100: EXTOp=01.
  - R-type and j: EXTOp=10.
- EXTOp is driven from ID onward and held through the last state of the instruction. The extender samples on negedge, so the value is stable at the negedge of every cycle that consumes the immediate. In IF, EXTOp=10.
- IF:
  - Outputs: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - IRWrite=PCWrite=`mem_ready`.
  - Advance to ID only when `mem_ready`=1; otherwise hold in IF.
- ID:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut).
  - Illegal opcode/funct: set `illegal`=1, next state IF.
  - Otherwise next state EX.
- EX:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUOp from funct; next WB.
  - I-ALU: ALUSrcA=1, ALUSrcB=10, ALUOp ADD/ADD/AND/OR; next WB.
  - lw/sw: ALUSrcA=1, ALUSrcB=10, ADD; next MEM.
  - beq: ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond=1, PCSource=01; next IF.
- MEM:
  - lw: MemRead=1; next WB when `mem_ready`, else hold.
  - sw: MemWrite=1; next IF when `mem_ready`, else hold. MemWrite stays high while held.
- WB: RegWrite=1, then next IF.
  - R-type: RegDst=1, MemToReg=0.
  - lw: RegDst=0, MemToReg=1.
  - I-ALU: RegDst=0, MemToReg=0.
- `illegal` clears only on reset. Execution continues with the next fetch.

## Timing
- Cycles per instruction with `mem_ready` held at 1:
  - j: 2 (macro on).
  - beq: 3.
  - R-type, I-ALU, sw: 4.
  - lw: 5.
- Each cycle of `mem_ready`=0 in IF or MEM adds exactly one cycle.
- `op_q` is updated only on the edge leaving ID. Opcode changes outside ID have no effect.
- `rst` asserted mid-instruction: outputs reach their reset values immediately, with no clock edge required. The first fetch begins on the first rising edge after deassertion.

## Configuration
- `MC_CTRL_JUMP_EN` defined:
  - j (000010) is decoded.
  - In ID it drives PCWrite=1 and PCSource=10, and EXTOp=10; next state IF.
- `MC_CTRL_JUMP_EN` not defined:
  - 000010 is treated as illegal: `illegal` sets and control returns to IF.
  - PCSource never equals 10.

## Test plan
- Reset with `mem_ready`=0 → state=0, all enables 0, illegal=0. Release reset, hold `mem_ready`=0 for 3 cycles → state stays 0 and IRWrite=0. Raise `mem_ready` → IRWrite=PCWrite=1 for one cycle, then state=1.
- `addi` (opcode 001000), `mem_ready`=1 → state sequence 0,1,2,4,0. EXTOp=01 at every negedge in ID/EX/WB. EX: ALUSrcB=10. WB: RegWrite=1, RegDst=0.
- `ori` 001101 → EXTOp=00 and ALUOp=011 in EX. R-type `slt` (funct 101010) → ALUOp=100, EXTOp=10, RegDst=1 in WB.
- `lw` with `mem_ready` low for 2 cycles in MEM → 7 total cycles. MemRead=1 throughout MEM. WB: MemToReg=1.
- `beq` → 3 cycles. EX: PCWriteCond=1, PCSource=01, ALUOp=001. No RegWrite or MemWrite at any point.
- Opcode 111111 → illegal=1 after ID, returns to IF. Opcode 000010: with macro, 2 cycles, PCSource=10; without macro, illegal=1. Assert `rst` during MEM of `sw` → MemWrite drops to 0 without a clock edge.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle IF/ID/EX/MEM/WB control FSM: drives datapath enables, mux selects and extender select.
// Optional j decode is enabled by defining MC_CTRL_JUMP_EN.
module mc_control_fsm #(
   parameter int STATE_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               RegDst,
   output logic               MemToReg,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [2:0]         ALUOp,
   output logic [1:0]         PCSource,
   output logic [1:0]         EXTOp,
   output logic [STATE_W-1:0] state,
   output logic               illegal
);
   typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
   typedef enum logic [2:0] {C_R, C_ALUI, C_LW, C_SW, C_BEQ, C_J, C_BAD} cls_t;

   localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                          OP_OR  = 3'b011, OP_SLT = 3'b100;

   state_t      state_q, state_n;
   logic [5:0]  op_q, funct_q;
   logic [5:0]  dec_op, dec_fn;
   cls_t        cls;
   logic [1:0]  ext_sel;
   logic [2:0]  ins_aluop;
   logic        pc_write_c, pc_write_cond_c, ir_write_c, reg_write_c, mem_read_c, mem_write_c;

   // In ID the IR is decoded live; later states use the copy captured when leaving ID.
   assign dec_op = (state_q == S_ID) ? opcode : op_q;
   assign dec_fn = (state_q == S_ID) ? funct  : funct_q;

   always_comb begin
      cls       = C_BAD;
      ext_sel   = 2'b10;
      ins_aluop = OP_ADD;
      case (dec_op)
         6'b000000: begin
            cls = C_R;
            case (dec_fn)
               6'b100000: ins_aluop = OP_ADD;
               6'b100010: ins_aluop = OP_SUB;
               6'b100100: ins_aluop = OP_AND;
               6'b100101: ins_aluop = OP_OR;
               6'b101010: ins_aluop = OP_SLT;
               default:   cls = C_BAD;
            endcase
         end
         6'b001000, 6'b001001: begin cls = C_ALUI; ext_sel = 2'b01; end
         6'b001100: begin cls = C_ALUI; ext_sel = 2'b00; ins_aluop = OP_AND; end
         6'b001101: begin cls = C_ALUI; ext_sel = 2'b00; ins_aluop = OP_OR; end
         6'b100011: begin cls = C_LW;   ext_sel = 2'b01; end
         6'b101011: begin cls = C_SW;   ext_sel = 2'b01; end
         6'b000100: begin cls = C_BEQ;  ext_sel = 2'b01; end
`ifdef MC_CTRL_JUMP_EN
         6'b000010: cls = C_J;
`endif
         default:   cls = C_BAD;
      endcase
   end

   always_comb begin
      state_n         = state_q;
      pc_write_c      = 1'b0;
      pc_write_cond_c = 1'b0;
      ir_write_c      = 1'b0;
      reg_write_c     = 1'b0;
      mem_read_c      = 1'b0;
      mem_write_c     = 1'b0;
      RegDst          = 1'b0;
      MemToReg        = 1'b0;
      ALUSrcA         = 1'b0;
      ALUSrcB         = 2'b00;
      ALUOp           = OP_ADD;
      PCSource        = 2'b00;
      EXTOp           = ext_sel;
      case (state_q)
         S_IF: begin
            EXTOp      = 2'b10;
            mem_read_c = 1'b1;
            ALUSrcB    = 2'b01;
            ir_write_c = mem_ready;
            pc_write_c = mem_ready;
            if (mem_ready) state_n = S_ID;
         end
         S_ID: begin
            ALUSrcB = 2'b11;
            case (cls)
               C_BAD:   state_n = S_IF;
               C_J: begin
                  pc_write_c = 1'b1;
                  PCSource   = 2'b10;
                  state_n    = S_IF;
               end
               default: state_n = S_EX;
            endcase
         end
         S_EX: begin
            ALUSrcA = 1'b1;
            case (cls)
               C_R:          begin ALUOp = ins_aluop; state_n = S_WB; end
               C_ALUI:       begin ALUSrcB = 2'b10; ALUOp = ins_aluop; state_n = S_WB; end
               C_LW, C_SW:   begin ALUSrcB = 2'b10; state_n = S_MEM; end
               C_BEQ: begin
                  ALUOp           = OP_SUB;
                  pc_write_cond_c = 1'b1;
                  PCSource        = 2'b01;
                  state_n         = S_IF;
               end
               default:      state_n = S_IF;
            endcase
         end
         S_MEM: begin
            if (cls == C_LW) begin
               mem_read_c = 1'b1;
               if (mem_ready) state_n = S_WB;
            end else begin
               mem_write_c = 1'b1;
               if (mem_ready) state_n = S_IF;
            end
         end
         S_WB: begin
            reg_write_c = 1'b1;
            RegDst      = (cls == C_R);
            MemToReg    = (cls == C_LW);
            state_n     = S_IF;
         end
         default: state_n = S_IF;
      endcase
   end

   // Enables are masked by the raw reset so they drop without waiting for a clock edge.
   assign PCWrite     = pc_write_c      & ~rst;
   assign PCWriteCond = pc_write_cond_c & ~rst;
   assign IRWrite     = ir_write_c      & ~rst;
   assign RegWrite    = reg_write_c     & ~rst;
   assign MemRead     = mem_read_c      & ~rst;
   assign MemWrite    = mem_write_c     & ~rst;
   assign state       = STATE_W'(state_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IF;
         op_q    <= 6'd0;
         funct_q <= 6'd0;
         illegal <= 1'b0;
      end else begin
         state_q <= state_n;
         if (state_q == S_ID) begin
            op_q    <= opcode;
            funct_q <= funct;
            if (cls == C_BAD) illegal <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized directed bench for mc_control_fsm against a per-instruction phase model.
module tb_mc_control_fsm;
   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite;
   logic       RegDst, MemToReg, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource, EXTOp;
   logic [2:0] ALUOp;
   logic [2:0] state;
   logic       illegal;

   mc_control_fsm #(.STATE_W(3)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .RegDst(RegDst), .MemToReg(MemToReg),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .EXTOp(EXTOp), .state(state), .illegal(illegal)
   );

   always #5 clk = ~clk;

   localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4;
   localparam int K_R = 0, K_ALUI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_BAD = 6;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      int         kind;
      logic [1:0] ext;
      logic [2:0] aop;
   } ins_t;

   ins_t tbl[15];
   int   n_assert = 0;
   int   n_fail   = 0;
   logic ill_m    = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected control word for one phase of an instruction, straight from the per-state output table.
   function automatic logic [17:0] exp_ctrl(input int ph, input ins_t e, input logic mr);
      logic pcw, pcwc, irw, rw, mrd, mw, rd, m2r, asa;
      logic [1:0] asb, pcs, ex;
      logic [2:0] aop;
      {pcw, pcwc, irw, rw, mrd, mw, rd, m2r, asa} = '0;
      asb = 2'b00; pcs = 2'b00; aop = 3'b000; ex = e.ext;
      case (ph)
         P_IF: begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; ex = 2'b10; end
         P_ID: begin
            asb = 2'b11;
            if (e.kind == K_J) begin pcw = 1'b1; pcs = 2'b10; end
         end
         P_EX: begin
            asa = 1'b1;
            if (e.kind == K_R) aop = e.aop;
            if (e.kind == K_ALUI) begin asb = 2'b10; aop = e.aop; end
            if (e.kind == K_LW || e.kind == K_SW) asb = 2'b10;
            if (e.kind == K_BEQ) begin aop = 3'b001; pcwc = 1'b1; pcs = 2'b01; end
         end
         P_MEM: begin mrd = (e.kind == K_LW); mw = (e.kind == K_SW); end
         P_WB: begin rw = 1'b1; rd = (e.kind == K_R); m2r = (e.kind == K_LW); end
         default: ;
      endcase
      return {pcw, pcwc, irw, rw, mrd, mw, rd, m2r, asa, asb, aop, pcs, ex};
   endfunction

   task automatic step(input int ph, input ins_t e, input logic mr,
                       input logic [5:0] op, input logic [5:0] fn);
      logic [17:0] act, mask;
      @(negedge clk);
      mem_ready = mr; opcode = op; funct = fn;
      #1;
      act  = {PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, RegDst, MemToReg,
              ALUSrcA, ALUSrcB, ALUOp, PCSource, EXTOp};
      mask = (e.kind == K_BAD && ph == P_ID) ? 18'h3fffc : 18'h3ffff;
      chk($sformatf("state p%0d op%b", ph, e.op), 32'(state), 32'(ph));
      chk($sformatf("ctrl p%0d op%b", ph, e.op), 32'(act & mask), 32'(exp_ctrl(ph, e, mr) & mask));
      chk($sformatf("illegal p%0d op%b", ph, e.op), 32'(illegal), 32'(ill_m));
   endtask

   task automatic run_instr(input ins_t e, input int if_st, input int mem_st);
      for (int i = 0; i <= if_st; i++)
         step(P_IF, e, i == if_st, (i == if_st) ? e.op : 6'($urandom), (i == if_st) ? e.fn : 6'($urandom));
      step(P_ID, e, 1'($urandom), e.op, e.fn);
      if (e.kind == K_BAD) ill_m = 1'b1;
      if (e.kind == K_R || e.kind == K_ALUI || e.kind == K_LW || e.kind == K_SW || e.kind == K_BEQ)
         step(P_EX, e, 1'($urandom), 6'($urandom), 6'($urandom));
      if (e.kind == K_LW || e.kind == K_SW)
         for (int i = 0; i <= mem_st; i++)
            step(P_MEM, e, i == mem_st, 6'($urandom), 6'($urandom));
      if (e.kind == K_R || e.kind == K_ALUI || e.kind == K_LW)
         step(P_WB, e, 1'($urandom), 6'($urandom), 6'($urandom));
      @(posedge clk);
      #1;
      chk($sformatf("return op%b", e.op), 32'(state), 32'(P_IF));
      chk($sformatf("illegal end op%b", e.op), 32'(illegal), 32'(ill_m));
   endtask

   initial begin
      ins_t e;
      tbl[0]  = '{6'b000000, 6'b100000, K_R,    2'b10, 3'b000};
      tbl[1]  = '{6'b000000, 6'b100010, K_R,    2'b10, 3'b001};
      tbl[2]  = '{6'b000000, 6'b100100, K_R,    2'b10, 3'b010};
      tbl[3]  = '{6'b000000, 6'b100101, K_R,    2'b10, 3'b011};
      tbl[4]  = '{6'b000000, 6'b101010, K_R,    2'b10, 3'b100};
      tbl[5]  = '{6'b000000, 6'b000001, K_BAD,  2'b10, 3'b000};
      tbl[6]  = '{6'b001000, 6'b010101, K_ALUI, 2'b01, 3'b000};
      tbl[7]  = '{6'b001001, 6'b110011, K_ALUI, 2'b01, 3'b000};
      tbl[8]  = '{6'b001100, 6'b000111, K_ALUI, 2'b00, 3'b010};
      tbl[9]  = '{6'b001101, 6'b101010, K_ALUI, 2'b00, 3'b011};
      tbl[10] = '{6'b100011, 6'b000000, K_LW,   2'b01, 3'b000};
      tbl[11] = '{6'b101011, 6'b111111, K_SW,   2'b01, 3'b000};
      tbl[12] = '{6'b000100, 6'b100010, K_BEQ,  2'b01, 3'b000};
`ifdef MC_CTRL_JUMP_EN
      tbl[13] = '{6'b000010, 6'b011000, K_J,    2'b10, 3'b000};
`else
      tbl[13] = '{6'b000010, 6'b011000, K_BAD,  2'b10, 3'b000};
`endif
      tbl[14] = '{6'b111111, 6'b100000, K_BAD,  2'b10, 3'b000};

      rst = 1'b1; mem_ready = 1'b0; opcode = 6'b101011; funct = 6'd0;
      @(negedge clk); #1;
      chk("reset state", 32'(state), 32'd0);
      chk("reset enables", 32'({PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite}), 32'd0);
      chk("reset illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_instr(tbl[6], 3, 0);   // addi after three IF stall cycles
      run_instr(tbl[9], 0, 0);   // ori
      run_instr(tbl[4], 0, 0);   // slt
      run_instr(tbl[10], 0, 2);  // lw with two MEM stalls
      run_instr(tbl[12], 0, 0);  // beq
      run_instr(tbl[11], 1, 1);  // sw
      run_instr(tbl[14], 0, 0);  // undecoded opcode
      run_instr(tbl[13], 0, 0);  // j
      run_instr(tbl[5], 0, 0);   // R-type with undecoded funct

      for (int n = 0; n < 60; n++) begin
         e = tbl[$urandom_range(0, 14)];
         if (e.op != 6'd0) e.fn = 6'($urandom);
         run_instr(e, $urandom_range(0, 2), $urandom_range(0, 2));
      end

      // Reset in the middle of a stalled sw store.
      e = tbl[11];
      step(P_IF, e, 1'b1, e.op, e.fn);
      step(P_ID, e, 1'b0, e.op, e.fn);
      step(P_EX, e, 1'b0, e.op, e.fn);
      step(P_MEM, e, 1'b0, e.op, e.fn);
      chk("sw memwrite held", 32'(MemWrite), 32'd1);
      rst = 1'b1;
      #1;
      chk("async rst memwrite", 32'(MemWrite), 32'd0);
      chk("async rst state", 32'(state), 32'd0);
      chk("async rst enables", 32'({PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite}), 32'd0);
      chk("async rst illegal", 32'(illegal), 32'd0);
      ill_m = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_instr(tbl[7], 0, 0);   // fetch resumes after reset
      run_instr(tbl[10], 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
